// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise-logic unit for the A64 logical op set.
// Keeps an architectural NZCV register that commits only on flag-setting handoffs.
`timescale 1ns/1ps

module logic_unit_pipe #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       select,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic [3:0]       nzcv
);

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("logic_unit_pipe: WIDTH must be 8..64 and a multiple of 4");
  end

  typedef enum logic [2:0] {
    OP_AND    = 3'b000,
    OP_ORR    = 3'b001,
    OP_EOR    = 3'b010,
    OP_BIC    = 3'b011,
    OP_ORN    = 3'b100,
    OP_EON    = 3'b101,
    OP_PASS_A = 3'b110,
    OP_PASS_B = 3'b111
  } op_e;

  localparam int unsigned LEAVES = WIDTH / 4;
  localparam int unsigned LEVELS = ($clog2(LEAVES) + 1) / 2;

  op_e              op;
  logic [WIDTH-1:0] op_result;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_result;
  logic             s1_setf;
  logic             s1_zero;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_setf;
  logic             s2_neg;
  logic             s2_zero;

  logic [3:0]       nzcv_q;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic             handoff;

  logic [4*LEAVES-1:0] zlvl;
  logic [4*LEAVES-1:0] znxt;

  assign op = op_e'(select);

  always_comb begin
    op_result = '0;
    case (op)
      OP_AND:    op_result = A & B;
      OP_ORR:    op_result = A | B;
      OP_EOR:    op_result = A ^ B;
      OP_BIC:    op_result = A & ~B;
      OP_ORN:    op_result = A | ~B;
      OP_EON:    op_result = A ^ ~B;
      OP_PASS_A: op_result = A;
      OP_PASS_B: op_result = B;
      default:   op_result = '0;
    endcase
  end

  // Zero detect as a 4-ary OR tree: nibble leaves, then fold groups of four
  // into the low bits each level until only bit 0 is left.
  always_comb begin
    zlvl = '0;
    znxt = '0;
    for (int unsigned i = 0; i < LEAVES; i++) begin
      zlvl[i] = |s1_result[4*i +: 4];
    end
    for (int unsigned lv = 0; lv < LEVELS; lv++) begin
      znxt = '0;
      for (int unsigned i = 0; i < LEAVES; i++) begin
        for (int unsigned m = 0; m < 4; m++) begin
          znxt[i] = znxt[i] | zlvl[4*i + m];
        end
      end
      zlvl = znxt;
    end
    s1_zero = ~zlvl[0];
  end

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready;
  assign handoff  = s2_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_result <= '0;
      s1_setf   <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_result <= op_result;
        s1_setf   <= set_flags;
      end else if (s1_adv) begin
        s1_valid  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_setf   <= 1'b0;
      s2_neg    <= 1'b0;
      s2_zero   <= 1'b0;
    end else begin
      if (s1_valid && s2_adv) begin
        s2_valid  <= 1'b1;
        s2_result <= s1_result;
        s2_setf   <= s1_setf;
        s2_neg    <= s1_result[WIDTH-1];
        s2_zero   <= s1_zero;
      end else if (s2_adv) begin
        s2_valid  <= 1'b0;
      end
    end
  end

  // Logical ops always clear C and V.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nzcv_q <= '0;
    end else if (handoff && s2_setf) begin
      nzcv_q <= {s2_neg, s2_zero, 2'b00};
    end
  end

  assign out_valid = s2_valid;
  assign result    = s2_result;
  assign negative  = s2_neg;
  assign zero      = s2_zero;
  assign nzcv      = nzcv_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe at WIDTH 64, 32 and 8 side by side.
// Expected beats come from a table-driven reference model; a monitor pops them.
`timescale 1ns/1ps

module tb_logic_unit_pipe;

  typedef struct {
    logic [63:0] r;
    logic        n;
    logic        z;
    logic        sf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iv, ir, ordy, sf, ov, neg, zer;
  logic [63:0] a   [3];
  logic [63:0] b   [3];
  logic [63:0] res [3];
  logic [2:0]  sel [3];
  logic [3:0]  nz  [3];
  logic [3:0]  mnz [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 64 : (g == 1) ? 32 : 8;
    logic [W-1:0] r;
    logic_unit_pipe #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .A         (a[g][W-1:0]),
      .B         (b[g][W-1:0]),
      .select    (sel[g]),
      .set_flags (sf[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .result    (r),
      .negative  (neg[g]),
      .zero      (zer[g]),
      .nzcv      (nz[g])
    );
    assign res[g] = 64'(r);
  end

  function automatic int unsigned wof(input int k);
    return (k == 0) ? 64 : (k == 1) ? 32 : 8;
  endfunction

  // Reference: the A64 logical op table on masked operands.
  function automatic exp_t model(input int unsigned w, input logic [63:0] av,
                                 input logic [63:0] bv, input logic [2:0] s,
                                 input logic f);
    exp_t e;
    logic [63:0] m, x, y, r;
    m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    x = av & m;
    y = bv & m;
    case (s)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = x & ~y;
      3'd4:    r = x | ~y;
      3'd5:    r = ~(x ^ y);
      3'd6:    r = x;
      default: r = y;
    endcase
    r    = r & m;
    e.r  = r;
    e.n  = r[w-1];
    e.z  = (r == 64'd0);
    e.sf = f;
    return e;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
  endfunction

  function automatic exp_t qfront(input int k);
    return (k == 0) ? q0[0] : (k == 1) ? q1[0] : q2[0];
  endfunction

  function automatic void qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else if (k == 1) void'(q1.pop_front());
    else void'(q2.pop_front());
  endfunction

  function automatic void qpush(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else if (k == 1) q1.push_back(e);
    else q2.push_back(e);
  endfunction

  function automatic void chk(input string nm, input int k,
                              input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h t=%0t", nm, k, act, exp_v, $time);
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat on DUT k until accepted; record expectation on accept.
  task automatic send(input int k, input logic [63:0] av, input logic [63:0] bv,
                      input logic [2:0] s, input logic f);
    bit done;
    done   = 1'b0;
    iv[k]  = 1'b1;
    a[k]   = av;
    b[k]   = bv;
    sel[k] = s;
    sf[k]  = f;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      #1;
      if (ir[k]) begin
        qpush(k, model(wof(k), av, bv, s, f));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_accept_timeout", k, 64'd0, 64'd1);
    iv[k] = 1'b0;
  endtask

  task automatic mon();
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        int   occ;
        exp_t e;
        occ = qsize(k);
        chk("in_ready", k, 64'(ir[k]), 64'(!(occ >= 2 && !ordy[k])));
        chk("nzcv", k, 64'(nz[k]), 64'(mnz[k]));
        if (occ == 0) begin
          chk("idle_out_valid", k, 64'(ov[k]), 64'd0);
        end else if (ov[k]) begin
          e = qfront(k);
          chk("result", k, res[k], e.r);
          chk("negative", k, 64'(neg[k]), 64'(e.n));
          chk("zero", k, 64'(zer[k]), 64'(e.z));
          if (ordy[k]) begin
            qpop(k);
            if (e.sf) mnz[k] = {e.n, e.z, 2'b00};
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iv    = '0;
    ordy  = '1;
    sf    = '0;
    for (int k = 0; k < 3; k++) begin
      a[k] = '0; b[k] = '0; sel[k] = '0; mnz[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    fork
      mon();
    join_none
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", k, 64'(ov[k]), 64'd0);
      chk("rst_result", k, res[k], 64'd0);
      chk("rst_nzcv", k, 64'(nz[k]), 64'd0);
    end
    rst_n = 1'b1;
    chk("in_ready_after_reset", 0, 64'(ir[0]), 64'd1);

    // Single ANDS and its two-stage latency
    send(0, 64'hFF00_FF00_0000_0001, 64'h0F0F_0000_0000_0001, 3'd0, 1'b1);
    chk("lat_s1_only", 0, 64'(ov[0]), 64'd0);
    cyc(1);
    chk("lat_out_valid", 0, 64'(ov[0]), 64'd1);
    chk("lat_result", 0, res[0], 64'h0F00_0000_0000_0001);
    chk("lat_neg", 0, 64'(neg[0]), 64'd0);
    chk("lat_zero", 0, 64'(zer[0]), 64'd0);
    cyc(1);
    chk("ands_nzcv", 0, 64'(nz[0]), 64'h0);

    // Zero and negative commits, then a non-flag beat leaving nzcv alone
    send(0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 3'd0, 1'b1);
    cyc(2);
    chk("zero_commit", 0, 64'(nz[0]), 64'h4);
    send(0, 64'd0, 64'd0, 3'd5, 1'b1);
    cyc(2);
    chk("neg_commit", 0, 64'(nz[0]), 64'h8);
    send(0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 3'd0, 1'b1);
    cyc(2);
    send(0, 64'd0, 64'd0, 3'd1, 1'b0);
    cyc(2);
    chk("nonflag_hold", 0, 64'(nz[0]), 64'h4);

    // Back-pressure: five beats against a 4-cycle stall
    ordy[0] = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(0, 64'h1234, 64'h00FF, 3'(i), 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bp_in_ready_low", 0, 64'(ir[0]), 64'd0);
        chk("bp_out_valid", 0, 64'(ov[0]), 64'd1);
        chk("bp_hold_result", 0, res[0], 64'h0034);
        ordy[0] = 1'b1;
      end
    join
    cyc(6);

    // Reset with two stalled flag-setting beats in flight
    ordy[0] = 1'b0;
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 3'd0, 1'b1);
    send(0, 64'd0, 64'd0, 3'd7, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 0, 64'(ov[0]), 64'd0);
    chk("mid_rst_result", 0, res[0], 64'd0);
    chk("mid_rst_nzcv", 0, 64'(nz[0]), 64'd0);
    chk("mid_rst_neg", 0, 64'(neg[0]), 64'd0);
    chk("mid_rst_zero", 0, 64'(zer[0]), 64'd0);
    q0.delete(); q1.delete(); q2.delete();
    for (int k = 0; k < 3; k++) mnz[k] = '0;
    ordy[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("in_ready_after_mid_rst", 0, 64'(ir[0]), 64'd1);
    cyc(4);
    chk("no_stale_beat", 0, 64'(ov[0]), 64'd0);
    chk("no_stale_commit", 0, 64'(nz[0]), 64'd0);

    // Narrow instance
    send(2, 64'h80, 64'hC0, 3'd0, 1'b1);
    cyc(2);
    chk("w8_nzcv", 2, 64'(nz[2]), 64'h8);

    // Random ops and handshakes on all widths
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        ordy[k] = ($urandom_range(0, 3) != 0);
        a[k]    = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
        b[k]    = ($urandom_range(0, 7) == 0) ? a[k] : {$urandom, $urandom};
        sel[k]  = 3'($urandom_range(0, 7));
        sf[k]   = $urandom_range(0, 1) != 0;
      end
      @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (iv[k] && ir[k]) qpush(k, model(wof(k), a[k], b[k], sel[k], sf[k]));
      end
      @(posedge clk);
      #1;
    end

    iv   = '0;
    ordy = '1;
    for (int t = 0; t < 50 && (q0.size() + q1.size() + q2.size()) != 0; t++) cyc(1);
    for (int k = 0; k < 3; k++) chk("drain_empty", k, 64'(qsize(k)), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise-logic execution unit for the 64-bit ARM datapath, the successor to the single-function combinational AND slice. It supports the full A64 logical op set (AND/ORR/EOR/BIC/ORN/EON plus pass-throughs) over a configurable width. It uses a two-stage valid/ready pipeline and keeps an architectural NZCV flag register that commits only for flag-setting ops. It sits in the EX stage beside the adder, and results drain to the EX/MEM register through the output handshake.

## Interface
- WIDTH, 64, operand/result width in bits; legal 8..64, multiple of 4.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts a beat this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- select  input  3  op: 000 AND, 001 ORR, 010 EOR, 011 BIC (A&~B), 100 ORN (A|~B), 101 EON (A^~B), 110 pass A, 111 pass B.
- set_flags  input  1  beat is a flag-setting op (ANDS/BICS).
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  op result.
- negative  output  1  result[WIDTH-1] of current out beat.
- zero  output  1  1 when current out result is all-zero.
- nzcv  output  4  architectural flag register {N,Z,C,V}.

## Operation
- Stage 1 (S1): on accept (in_valid && in_ready), it computes the op combinationally and registers s1_result, s1_setf, and s1_valid=1.
- Stage 2 (S2): on advance, it registers the S1 contents plus s2_neg=s1_result[WIDTH-1] and s2_zero=~|s1_result. The zero reduction is a 4-input OR tree, WIDTH/4 leaves.
- Outputs result/negative/zero are driven from S2 registers. They are meaningful only while out_valid=1 and hold stable while out_valid && !out_ready.
- Flag commit happens on handoff (out_valid && out_ready && s2_setf): nzcv <= {s2_neg, s2_zero, 0, 0}. Logical ops always clear C and V.
- Non-flag-setting beats never modify nzcv.
- nzcv is visible from the cycle after commit.
- Pass A/B ops still generate per-beat N/Z. They commit them if set_flags=1.
- No internal op reordering: beats leave in acceptance order.

## Timing
- Latency is 2 cycles, accept edge to out_valid, when unstalled. Throughput is 1 beat/cycle.
- s2_adv = !s2_valid || out_ready.
- s1_adv = !s1_valid || s2_adv.
- in_ready = s1_adv. This is combinational from out_ready and has no dependence on in_valid.
- S2 loads when s1_valid && s2_adv. It clears (s2_valid<=0) when a beat is consumed while S1 is empty.
- S1 loads on accept. It clears when it advances without a new accept.
- Full: both stages valid and out_ready=0 gives in_ready=0. A, B and select are ignored.
- Simultaneous consume at S2, shift S1 to S2, and accept into S1 in one cycle gives no bubble and no loss.
- Back-to-back flag-setting beats commit in order, one per handoff cycle.
- Reset (async assert, any cycle including mid-stall) forces:
  - s1_valid=s2_valid=0, so out_valid=0.
  - result=0, negative=0, zero=0, nzcv=4'b0000.
  - Result/flag registers clear, not hold.
  - In-flight beats are discarded and never commit.
- in_ready is 1 in the first cycle after reset deasserts. Deassertion is expected synchronous to clk.

## Test plan
- Reset, then a single ANDS (A=64'hFF00_FF00_0000_0001, B=64'h0F0F_0000_0000_0001, set_flags=1) with out_ready=1:
  - out_valid rises 2 cycles after accept with result=64'h0F00_0000_0000_0001, negative=0, zero=0.
  - nzcv=0000 the next cycle.
- Zero/negative commit:
  - AND A=64'hAAAA..., B=64'h5555..., setf=1 gives zero=1 and nzcv=0100.
  - Then EON A=0, B=0, setf=1 gives result=all-ones, negative=1, and nzcv=1000.
- Non-flag op: with nzcv=0100, ORR A=0, B=0, setf=0 gives result=0 and zero=1, but nzcv stays 0100.
- Back-pressure: stream 5 beats (AND, ORR, EOR, BIC, ORN, all A=64'h1234, B=64'h00FF) with out_ready=0 for 4 cycles.
  - in_ready drops after 2 accepts and result holds 64'h0034.
  - After release, the results arrive in order: 0034, 12FF, 12CB, 1200, FFFF_FFFF_FFFF_FF34.
  - No beats are dropped or duplicated.
- Reset mid-operation: with 2 valid flag-setting beats stalled, assert reset.
  - out_valid=0, result=0 and nzcv=0000 immediately (asynchronously).
  - After release, no stale beat appears.
- Parameter sweep WIDTH=8, AND A=8'h80, B=8'hC0, setf=1 gives result=8'h80, negative=1, nzcv=1000. Random ops/handshake are checked against a reference model for WIDTH in {8,32,64}.
